// File: rtl/mem_access_ctrl_if.sv
// CPU request/response and word-memory port bundle for mem_access_ctrl.
// master = CPU plus memory environment, slave = the controller.
interface mem_access_ctrl_if;
  logic        req_mem_access;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        data_inout_access_type;
  logic [1:0]  data_inout_access_size;
  logic [31:0] data_out;
  logic        wait_for_mem;
  logic        access_err;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_word_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output req_mem_access, addr, data_in, data_inout_access_type, data_inout_access_size,
    output mem_rdata, mem_ready,
    input  data_out, wait_for_mem, access_err,
    input  mem_en, mem_we, mem_word_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_mem_access, addr, data_in, data_inout_access_type, data_inout_access_size,
    input  mem_rdata, mem_ready,
    output data_out, wait_for_mem, access_err,
    output mem_en, mem_we, mem_word_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// CPU byte/half/word access onto a 32-bit word memory; 2-cycle minimum latency, CPU stalled via wait_for_mem until mem_ready.
// Define MEM_ACCESS_CTRL_TIMEOUT_EN to abort WAIT_MEM with access_err after TIMEOUT_CYCLES cycles.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_access_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_MEM = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]  state, state_nxt;
  logic [31:0] addr_q, wdata_q, data_out_q;
  logic        we_q, err_q;
  logic [1:0]  size_q;
  logic        illegal, mem_en, timeout;
  logic [3:0]  be_raw;
  logic [31:0] rdata_sh, rdata_ext;

  always_comb begin
    illegal = 1'b0;
    case (bus.data_inout_access_size)
      2'd0:    illegal = 1'b0;
      2'd1:    illegal = bus.addr[0];
      2'd2:    illegal = (bus.addr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    be_raw    = 4'b1111;
    rdata_sh  = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    rdata_ext = rdata_sh;
    case (size_q)
      2'd0: begin
        be_raw    = 4'b0001 << addr_q[1:0];
        rdata_ext = {24'd0, rdata_sh[7:0]};
      end
      2'd1: begin
        be_raw    = 4'b0011 << addr_q[1:0];
        rdata_ext = {16'd0, rdata_sh[15:0]};
      end
      default: begin
        be_raw    = 4'b1111;
        rdata_ext = rdata_sh;
      end
    endcase
  end

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      to_cnt <= '0;
    else if (state != WAIT_MEM)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  // Fires in the last permitted WAIT_MEM cycle so exactly TIMEOUT_CYCLES are spent waiting.
  assign timeout = (state == WAIT_MEM) && !bus.mem_ready && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.req_mem_access) state_nxt = illegal ? RESP : ISSUE;
      ISSUE:    state_nxt = bus.mem_ready ? RESP : WAIT_MEM;
      WAIT_MEM: if (bus.mem_ready || timeout) state_nxt = RESP;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.req_mem_access) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.data_in;
        we_q    <= bus.data_inout_access_type;
        size_q  <= bus.data_inout_access_size;
        err_q   <= illegal;
        if (illegal) data_out_q <= '0;
      end
      if (mem_en && bus.mem_ready && !we_q) data_out_q <= rdata_ext;
      if (timeout) begin
        err_q      <= 1'b1;
        data_out_q <= '0;
      end
    end
  end

  // Memory-side outputs are gated by mem_en so nothing leaks outside an issued access.
  assign mem_en            = (state == ISSUE) || (state == WAIT_MEM);
  assign bus.mem_en        = mem_en;
  assign bus.mem_we        = mem_en & we_q;
  assign bus.mem_be        = mem_en ? be_raw : 4'b0000;
  assign bus.mem_word_addr = mem_en ? addr_q[31:2] : 30'd0;
  assign bus.mem_wdata     = mem_en ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
  assign bus.wait_for_mem  = ((state == IDLE) && bus.req_mem_access) || mem_en;
  assign bus.access_err    = (state == RESP) && err_q;
  assign bus.data_out      = data_out_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table, hand-written corner sequences, random accesses vs a model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic [1:0]  size;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] model_dout = 32'd0;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference: alignment/lane rules evaluated arithmetically from byte offset and access width.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] d, input logic w,
                                 input logic [1:0] sz, input logic [31:0] rd, input int dly,
                                 input logic [31:0] prev);
    vec_t v;
    int off, nb;
    off = int'(a[1:0]);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v.addr = a; v.din = d; v.we = w; v.size = sz; v.rdata = rd; v.dly = dly;
    v.exp_err   = (sz == 2'd3) || ((off % nb) != 0);
    v.exp_be    = v.exp_err ? 4'd0 : 4'(((1 << nb) - 1) << off);
    v.exp_wdata = 32'((64'(d) << (8 * off)) & 64'(bytemask(v.exp_be)));
    if (v.exp_err)
      v.exp_dout = 32'd0;
    else if (w)
      v.exp_dout = prev;
    else
      v.exp_dout = 32'((64'(rd) >> (8 * off)) & ((64'h1 << (8 * nb)) - 64'h1));
    return v;
  endfunction

  // Called and returns at posedge+1; request is held for one cycle only, inputs scrambled afterwards.
  task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                            input logic [1:0] sz, input logic [31:0] rd, input int dly,
                            output bit done, output int n_wait, output int n_en, output int n_we,
                            output logic [3:0] be, output logic [31:0] wd, output logic [29:0] wa,
                            output logic err, output logic [31:0] dout);
    done = 1'b0; n_wait = 0; n_en = 0; n_we = 0;
    be = 4'd0; wd = 32'd0; wa = 30'd0; err = 1'b0; dout = 32'd0;
    bus.req_mem_access = 1'b1;
    bus.addr = a; bus.data_in = d; bus.data_inout_access_type = w;
    bus.data_inout_access_size = sz; bus.mem_rdata = rd;
    for (int k = 0; k < 60 && !done; k++) begin
      if (k > 0) begin
        bus.req_mem_access = 1'b0;
        bus.addr = $urandom; bus.data_in = $urandom;
        bus.data_inout_access_type = 1'($urandom);
        bus.data_inout_access_size = 2'($urandom);
      end
      bus.mem_ready = (k == 1 + dly);
      @(negedge clk);
      if (bus.wait_for_mem) n_wait++;
      else begin
        done = 1'b1;
        err  = bus.access_err;
        dout = bus.data_out;
      end
      if (bus.mem_en) begin
        n_en++;
        if (n_en == 1) begin
          be = bus.mem_be; wd = bus.mem_wdata; wa = bus.mem_word_addr;
        end
      end
      if (bus.mem_we) n_we++;
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    bit done; int n_wait, n_en, n_we;
    logic [3:0] be; logic [31:0] wd, dout; logic [29:0] wa; logic err;
    run_access(v.addr, v.din, v.we, v.size, v.rdata, v.dly,
               done, n_wait, n_en, n_we, be, wd, wa, err, dout);
    chk("resp_seen", 64'(done), 64'd1);
    chk("wait_cycles", 64'(n_wait), v.exp_err ? 64'd1 : 64'(2 + v.dly));
    chk("en_cycles", 64'(n_en), v.exp_err ? 64'd0 : 64'(1 + v.dly));
    chk("we_cycles", 64'(n_we), (v.we && !v.exp_err) ? 64'(1 + v.dly) : 64'd0);
    if (!v.exp_err) begin
      chk("mem_be", 64'(be), 64'(v.exp_be));
      chk("word_addr", 64'(wa), 64'(v.addr[31:2]));
      if (v.we) chk("wdata", 64'(wd & bytemask(v.exp_be)), 64'(v.exp_wdata));
    end
    chk("access_err", 64'(err), 64'(v.exp_err));
    chk("data_out", 64'(dout), 64'(v.exp_dout));
    chk("err_pulse_end", 64'(bus.access_err), 64'd0);
    model_dout = v.exp_dout;
  endtask

  initial begin
    bit done; int n_wait, n_en, n_we;
    logic [3:0] be; logic [31:0] wd, dout; logic [29:0] wa; logic err;
    vec_t v;

    bus.req_mem_access = 1'b0; bus.addr = 32'd0; bus.data_in = 32'd0;
    bus.data_inout_access_type = 1'b0; bus.data_inout_access_size = 2'd0;
    bus.mem_rdata = 32'd0; bus.mem_ready = 1'b0;

    tbl[0] = '{32'h100, 32'h0,        1'b0, 2'd2, 32'hDEADBEEF, 0, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[1] = '{32'h103, 32'h5A,       1'b1, 2'd0, 32'h0,        0, 4'h8, 32'h5A000000, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{32'h102, 32'h0,        1'b0, 2'd1, 32'h12345678, 3, 4'hC, 32'h0,        1'b0, 32'h00001234};
    tbl[3] = '{32'h101, 32'h0,        1'b0, 2'd2, 32'hFFFFFFFF, 0, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[4] = '{32'h201, 32'h0,        1'b0, 2'd0, 32'hAABBCCDD, 1, 4'h2, 32'h0,        1'b0, 32'h000000CC};
    tbl[5] = '{32'h200, 32'h0,        1'b0, 2'd3, 32'h1,        0, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[6] = '{32'h302, 32'hBEEF,     1'b1, 2'd1, 32'h0,        2, 4'hC, 32'hBEEF0000, 1'b0, 32'h0};
    tbl[7] = '{32'h303, 32'h0,        1'b1, 2'd1, 32'h0,        0, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[8] = '{32'h400, 32'h11223344, 1'b1, 2'd2, 32'h0,        0, 4'hF, 32'h11223344, 1'b0, 32'h0};
    tbl[9] = '{32'h400, 32'h0,        1'b0, 2'd1, 32'h87654321, 0, 4'h3, 32'h0,        1'b0, 32'h00004321};

    // Reset state
    #12;
    chk("rst_data_out", 64'(bus.data_out), 64'd0);
    chk("rst_access_err", 64'(bus.access_err), 64'd0);
    chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_be", 64'(bus.mem_be), 64'd0);
    chk("rst_word_addr", 64'(bus.mem_word_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_wait", 64'(bus.wait_for_mem), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) apply_vec(tbl[i]);

    // Back-to-back: request held high through RESP restarts from IDLE.
    bus.req_mem_access = 1'b1; bus.addr = 32'h700; bus.data_inout_access_size = 2'd2;
    bus.data_inout_access_type = 1'b0; bus.mem_rdata = 32'h0BADF00D; bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("b2b_idle_wait", 64'(bus.wait_for_mem), 64'd1);
    @(posedge clk); #1; bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("b2b_issue_en", 64'(bus.mem_en), 64'd1);
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("b2b_resp_wait", 64'(bus.wait_for_mem), 64'd0);
    chk("b2b_resp_dout", 64'(bus.data_out), 64'h0BADF00D);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_idle2_wait", 64'(bus.wait_for_mem), 64'd1);
    chk("b2b_idle2_en", 64'(bus.mem_en), 64'd0);
    @(posedge clk); #1; bus.mem_ready = 1'b1; bus.req_mem_access = 1'b0;
    @(negedge clk);
    chk("b2b_issue2_en", 64'(bus.mem_en), 64'd1);
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("b2b_resp2_wait", 64'(bus.wait_for_mem), 64'd0);
    @(posedge clk); #1;

    // Reset during WAIT_MEM aborts immediately with no response.
    bus.req_mem_access = 1'b1; bus.addr = 32'h500; bus.data_in = 32'h55;
    bus.data_inout_access_type = 1'b1; bus.data_inout_access_size = 2'd2;
    @(posedge clk); #1; bus.req_mem_access = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_en_before", 64'(bus.mem_en), 64'd1);
    chk("mid_we_before", 64'(bus.mem_we), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_en_async", 64'(bus.mem_en), 64'd0);
    chk("mid_we_async", 64'(bus.mem_we), 64'd0);
    chk("mid_be_async", 64'(bus.mem_be), 64'd0);
    chk("mid_wdata_async", 64'(bus.mem_wdata), 64'd0);
    chk("mid_dout_async", 64'(bus.data_out), 64'd0);
    chk("mid_wait_async", 64'(bus.wait_for_mem), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_err", 64'(bus.access_err), 64'd0);
      chk("post_rst_en", 64'(bus.mem_en), 64'd0);
    end
    model_dout = 32'd0;
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      v = model($urandom, $urandom, 1'($urandom), 2'($urandom_range(0, 3)),
                $urandom, $urandom_range(0, 4), model_dout);
      apply_vec(v);
    end

    // Memory that never answers.
    run_access(32'h600, 32'h0, 1'b0, 2'd2, 32'hCAFEF00D, 1000,
               done, n_wait, n_en, n_we, be, wd, wa, err, dout);
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    chk("to_resp_seen", 64'(done), 64'd1);
    chk("to_wait_cycles", 64'(n_wait), 64'd17);
    chk("to_en_cycles", 64'(n_en), 64'd16);
    chk("to_access_err", 64'(err), 64'd1);
    chk("to_data_out", 64'(dout), 64'd0);
    chk("to_en_after", 64'(bus.mem_en), 64'd0);
`else
    chk("hang_no_resp", 64'(done), 64'd0);
    chk("hang_wait_cycles", 64'(n_wait), 64'd60);
    chk("hang_en_cycles", 64'(n_en), 64'd59);
    chk("hang_wait_now", 64'(bus.wait_for_mem), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("hang_rst_en", 64'(bus.mem_en), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum cycles spent in WAIT_MEM before abort (used only with the Configuration macro).
REQ-002 Port clk  in  1: single clock; all state updates on posedge.
REQ-003 Port reset_n  in  1: reset, asynchronous and active-low.
REQ-004 Port req_mem_access  in  1: CPU access request, level, sampled only in IDLE.
REQ-005 Port addr  in  32: CPU byte address.
REQ-006 Port data_in  in  32: CPU write data, right-justified.
REQ-007 Port data_inout_access_type  in  1: 0 = read, 1 = write.
REQ-008 Port data_inout_access_size  in  2: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = reserved.
REQ-009 Port data_out  out  32: read data to the CPU, right-justified and zero-extended.
REQ-010 Port wait_for_mem  out  1: high while the CPU must stall.
REQ-011 Port access_err  out  1: one-cycle pulse on a misaligned, reserved-size or timed-out access.
REQ-012 Port mem_en  out  1: memory strobe.
REQ-013 Port mem_we  out  1: memory write enable.
REQ-014 Port mem_word_addr  out  30: word address, addr[31:2].
REQ-015 Port mem_be  out  4: byte enables; bit n selects bits [8n+7:8n].
REQ-016 Port mem_wdata  out  32: lane-aligned write data.
REQ-017 Port mem_rdata  in  32: memory read word.
REQ-018 Port mem_ready  in  1: memory completion; valid only while mem_en is high.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_MEM and RESP.
REQ-020 IDLE with req_mem_access=1 SHALL latch addr, data_in, type and size, and SHALL go to ISSUE, or to RESP with an error flag if the access is illegal.
REQ-021 An access SHALL be illegal if size=3, if size=1 and addr[0]=1, or if size=2 and addr[1:0]!=0.
REQ-022 ISSUE SHALL assert mem_en for one cycle with mem_word_addr, mem_be, mem_we and mem_wdata driven from the latched values, then go to WAIT_MEM.
REQ-023 WAIT_MEM SHALL hold mem_en high until mem_ready=1, capture mem_rdata in that cycle, then go to RESP.
REQ-024 mem_ready arriving in the ISSUE cycle SHALL be honoured, giving ISSUE->RESP directly.
REQ-025 mem_be SHALL be: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; size 2 -> 4'b1111.
REQ-026 mem_wdata SHALL be data_in shifted left by 8*addr[1:0]; bytes not covered by mem_be are don't-care.
REQ-027 For reads, data_out SHALL be mem_rdata>>8*addr[1:0], masked to the access size and zero-extended.
REQ-028 data_out SHALL hold its value until the next completed read.
REQ-029 On writes, data_out SHALL be unchanged.
REQ-030 On errors, data_out SHALL be zero.
REQ-031 wait_for_mem SHALL be combinationally high in IDLE when req_mem_access=1, and high in ISSUE and WAIT_MEM.
REQ-032 wait_for_mem SHALL be low in RESP and in IDLE without a request.
REQ-033 Minimum latency SHALL be request in cycle N -> wait_for_mem low in cycle N+2 (mem_ready in ISSUE).
REQ-034 RESP SHALL last one cycle, pulse access_err if flagged, and return to IDLE; a request still present in IDLE starts a new access (back-to-back allowed).
REQ-035 mem_en and mem_we SHALL never be asserted for an illegal access.

Reset
REQ-036 While reset_n=0 the block SHALL be in IDLE with data_out=0, access_err=0, mem_en=0, mem_we=0, mem_be=0, mem_word_addr=0, mem_wdata=0 and all latches cleared.
REQ-037 Reset asserted mid-access SHALL abort immediately (mem_en drops asynchronously) and SHALL not generate a response.

Configuration
REQ-038 With MEM_ACCESS_CTRL_TIMEOUT_EN defined, a counter SHALL run in WAIT_MEM; reaching TIMEOUT_CYCLES without mem_ready SHALL drop mem_en and go to RESP with access_err.
REQ-039 Without MEM_ACCESS_CTRL_TIMEOUT_EN, no counter SHALL exist and WAIT_MEM SHALL wait indefinitely.

Verification
REQ-040 Word read: addr=0x100, size=2, mem_rdata=0xDEADBEEF, mem_ready in ISSUE -> mem_be=1111, data_out=0xDEADBEEF, wait_for_mem low 2 cycles after the request.
REQ-041 Byte write: addr=0x103, size=0, data_in=0x5A -> mem_be=1000, mem_wdata[31:24]=0x5A, mem_we=1 for the single ISSUE cycle.
REQ-042 Halfword read: addr=0x102, mem_rdata=0x12345678, mem_ready delayed 3 cycles -> data_out=0x00001234, wait_for_mem high for 5 cycles.
REQ-043 Misaligned: addr=0x101, size=2 -> mem_en never asserted, access_err pulses once, data_out=0.
REQ-044 Timeout (macro defined, TIMEOUT_CYCLES=15): mem_ready never asserted -> access_err after 15 WAIT_MEM cycles; without the macro, wait_for_mem stays high.
REQ-045 reset_n pulsed low during WAIT_MEM -> mem_en=0 at once, IDLE on release, no access_err.
